// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: funct3 codes,
// FSM states and size/span/legality decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} lsu_state_t;

    // size is funct3[1:0]: 0 byte, 1 half, 2 word
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic spans(input logic [1:0] size, input logic [1:0] off);
        return ({1'b0, off} + size_bytes(size)) > 3'd4;
    endfunction

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
// master: pipeline + memory side; slave: the LSU.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_we, dm_addr, dm_wd
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_we, dm_addr, dm_wd
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store shift/mask, span detection and
// load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  mask,
    output logic [63:0] wdata_sh,
    output logic        span,
    output logic [31:0] rdata
);
    logic [31:0] rd_word;

    always_comb begin
        mask     = {4'b0000, size_mask(funct3[1:0])} << offset;
        wdata_sh = {32'h0, wdata} << {offset, 3'b000};
        span     = spans(funct3[1:0], offset);
        rd_word  = 32'({hi, lo} >> {offset, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{rd_word[7]}}, rd_word[7:0]};
            F3_H:    rdata = {{16{rd_word[15]}}, rd_word[15:0]};
            F3_BU:   rdata = {24'h0, rd_word[7:0]};
            F3_HU:   rdata = {16'h0, rd_word[15:0]};
            F3_W:    rdata = rd_word;
            default: rdata = rd_word;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: sub-word RMW, two-word split, load extension.
// Optional MISALIGN_TRAP_EN turns size-misaligned accesses into errors.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic clk,
    input  logic rst,
    mem_lsu_if.slave bus
);
    lsu_state_t  state_q, state_d;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q, lo_q, hi_q;

    logic [29:0] req_idx;
    logic        req_span, req_oor, req_mis, req_err, accept;
    logic [7:0]  mask;
    logic [63:0] wdata_sh;
    logic        span;
    logic [31:0] ld_data;

    lsu_align u_align (
        .funct3   (f3_q),
        .offset   (off_q),
        .wdata    (wdata_q),
        .lo       (lo_q),
        .hi       (hi_q),
        .mask     (mask),
        .wdata_sh (wdata_sh),
        .span     (span),
        .rdata    (ld_data)
    );

    assign req_idx  = bus.req_addr[31:2];
    assign req_span = spans(bus.req_funct3[1:0], bus.req_addr[1:0]);
    // Covers both the first word and, when spanning, the second one
    assign req_oor  = ({1'b0, req_idx} + {30'h0, req_span}) >= 31'(MEM_WORDS);
`ifdef MISALIGN_TRAP_EN
    assign req_mis  = misaligned(bus.req_funct3[1:0], bus.req_addr[1:0]);
`else
    assign req_mis  = 1'b0;
`endif
    assign req_err  = f3_illegal(bus.req_we, bus.req_funct3) || req_oor || req_mis;

    assign bus.req_ready = ((state_q == IDLE) || (state_q == RESP)) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d       = state_q;
        bus.rsp_valid = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h0;
        bus.dm_wd     = 32'h0;
        unique case (state_q)
            IDLE: ;
            ACC1: begin
                bus.dm_addr = {idx_q, 2'b00};
                bus.dm_we   = we_q;
                for (int b = 0; b < 4; b++) begin
                    bus.dm_wd[8*b +: 8] = mask[b] ? wdata_sh[8*b +: 8] : bus.dm_rd[8*b +: 8];
                end
                state_d = span ? ACC2 : RESP;
            end
            ACC2: begin
                bus.dm_addr = {idx_q + 30'd1, 2'b00};
                bus.dm_we   = we_q;
                for (int b = 0; b < 4; b++) begin
                    bus.dm_wd[8*b +: 8] = mask[4+b] ? wdata_sh[32+8*b +: 8]
                                                    : bus.dm_rd[8*b +: 8];
                end
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
        endcase
        if (accept) begin
            state_d = req_err ? RESP : ACC1;
        end
        // An abort must not commit a pending write or emit a response
        if (rst) begin
            bus.rsp_valid = 1'b0;
            bus.dm_we     = 1'b0;
        end
    end

    assign bus.rsp_err   = bus.rsp_valid && err_q;
    assign bus.rsp_rdata = (bus.rsp_valid && !err_q && !we_q) ? ld_data : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            idx_q   <= 30'h0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we;
                err_q   <= req_err;
                f3_q    <= bus.req_funct3;
                off_q   <= bus.req_addr[1:0];
                idx_q   <= req_idx;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == ACC1 && !we_q) lo_q <= bus.dm_rd;
            if (state_q == ACC2 && !we_q) hi_q <= bus.dm_rd;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a behavioural 64-word data memory.
module tb_mem_lsu;
    import lsu_pkg::*;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  lat;
    } op_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] mem [64];
    int          we_cnt;
    int          errors;
    int          checks;
    exp_t        sb [$];

    mem_lsu_if bus ();

    mem_lsu #(.MEM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.dm_rd = mem[bus.dm_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.dm_we) begin
            mem[bus.dm_addr[7:2]] <= bus.dm_wd;
            we_cnt <= we_cnt + 1;
        end
    end

    function automatic op_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic err,
                               input logic [31:0] rdata, input logic [3:0] lat);
        return '{we, f3, addr, wd, err, rdata, lat};
    endfunction

    // Called at a negedge; returns at the negedge where rsp_valid was seen.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic g_err,
                          output logic [31:0] g_rd, output logic [3:0] g_lat);
        int n;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        g_err = 1'bx;
        g_rd  = 32'hx;
        g_lat = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                g_lat = 4'(i);
                g_err = bus.rsp_err;
                g_rd  = bus.rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h8;
        bus.req_wdata  = 32'h12345678;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b err=%b want 0/0", bus.rsp_valid, bus.rsp_err);
        end
        checks++;
        if (bus.dm_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_dm_we: got %b want 0", bus.dm_we);
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata);
        end
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b want 1", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_dropped_rsp: got %b want 0", bus.rsp_valid);
        end
        checks++;
        if (we_cnt !== 0 || mem[2] !== 32'h0) begin
            errors++;
            $display("FAIL reset_dropped_write: got we_cnt=%0d dm2=%h want 0/0", we_cnt, mem[2]);
        end
    endtask

    task automatic test_word();
        op_t ops [2];
        exp_t e;
        logic g_err;
        logic [31:0] g_rd;
        logic [3:0] g_lat;
        ops[0] = mk(1'b1, F3_W, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0, 4'd2);
        ops[1] = mk(1'b0, F3_W, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 4'd2);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{ops[i].err, ops[i].rdata, ops[i].lat});
            do_req(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, g_err, g_rd, g_lat);
            e = sb.pop_front();
            checks++;
            if ({g_err, g_rd, g_lat} !== {e.err, e.rdata, e.lat}) begin
                errors++;
                $display("FAIL word[%0d]: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                         i, g_err, g_rd, g_lat, e.err, e.rdata, e.lat);
            end
        end
        checks++;
        if (mem[2] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_mem: got dm2=%h want deadbeef", mem[2]);
        end
    endtask

    task automatic test_subword();
        op_t ops [4];
        exp_t e;
        logic g_err;
        logic [31:0] g_rd;
        logic [3:0] g_lat;
        mem[3] <= 32'h11223344;
        ops[0] = mk(1'b1, F3_B,  32'h0D, 32'h000000A5, 1'b0, 32'h0, 4'd2);
        ops[1] = mk(1'b0, F3_B,  32'h0D, 32'h0, 1'b0, 32'hFFFFFFA5, 4'd2);
        ops[2] = mk(1'b0, F3_BU, 32'h0D, 32'h0, 1'b0, 32'h000000A5, 4'd2);
        ops[3] = mk(1'b0, F3_H,  32'h0E, 32'h0, 1'b0, 32'h00001122, 4'd2);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_t'{ops[i].err, ops[i].rdata, ops[i].lat});
            do_req(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, g_err, g_rd, g_lat);
            e = sb.pop_front();
            checks++;
            if ({g_err, g_rd, g_lat} !== {e.err, e.rdata, e.lat}) begin
                errors++;
                $display("FAIL subword[%0d]: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                         i, g_err, g_rd, g_lat, e.err, e.rdata, e.lat);
            end
        end
        checks++;
        if (mem[3] !== 32'h1122A544) begin
            errors++;
            $display("FAIL subword_mem: got dm3=%h want 1122a544", mem[3]);
        end
    endtask

    task automatic test_span();
        op_t ops [2];
        exp_t e;
        logic g_err;
        logic [31:0] g_rd;
        logic [3:0] g_lat;
        int w0;
        mem[3] <= 32'h0;
        mem[4] <= 32'h0;
        w0 = we_cnt;
        ops[0] = mk(1'b1, F3_W, 32'h0E, 32'hCAFEF00D, TRAP, 32'h0, TRAP ? 4'd1 : 4'd3);
        ops[1] = mk(1'b0, F3_W, 32'h0E, 32'h0, TRAP, TRAP ? 32'h0 : 32'hCAFEF00D,
                    TRAP ? 4'd1 : 4'd3);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{ops[i].err, ops[i].rdata, ops[i].lat});
            do_req(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, g_err, g_rd, g_lat);
            e = sb.pop_front();
            checks++;
            if ({g_err, g_rd, g_lat} !== {e.err, e.rdata, e.lat}) begin
                errors++;
                $display("FAIL span[%0d]: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                         i, g_err, g_rd, g_lat, e.err, e.rdata, e.lat);
            end
        end
        checks++;
        if (mem[3] !== (TRAP ? 32'h0 : 32'hF00D0000)) begin
            errors++;
            $display("FAIL span_mem3: got %h want %h", mem[3], TRAP ? 32'h0 : 32'hF00D0000);
        end
        checks++;
        if (mem[4] !== (TRAP ? 32'h0 : 32'h0000CAFE)) begin
            errors++;
            $display("FAIL span_mem4: got %h want %h", mem[4], TRAP ? 32'h0 : 32'h0000CAFE);
        end
        checks++;
        if ((we_cnt - w0) !== (TRAP ? 0 : 2)) begin
            errors++;
            $display("FAIL span_writes: got %0d want %0d", we_cnt - w0, TRAP ? 0 : 2);
        end
    endtask

    task automatic test_range();
        op_t ops [2];
        exp_t e;
        logic g_err;
        logic [31:0] g_rd;
        logic [3:0] g_lat;
        int w0;
        mem[63] <= 32'h89ABCDEF;
        w0 = we_cnt;
        ops[0] = mk(1'b0, F3_W, 32'h100, 32'h0, 1'b1, 32'h0, 4'd1);
        ops[1] = mk(1'b1, F3_H, 32'h0FF, 32'h00005A5A, 1'b1, 32'h0, 4'd1);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{ops[i].err, ops[i].rdata, ops[i].lat});
            do_req(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, g_err, g_rd, g_lat);
            e = sb.pop_front();
            checks++;
            if ({g_err, g_rd, g_lat} !== {e.err, e.rdata, e.lat}) begin
                errors++;
                $display("FAIL range[%0d]: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                         i, g_err, g_rd, g_lat, e.err, e.rdata, e.lat);
            end
        end
        checks++;
        if (mem[63] !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL range_mem63: got %h want 89abcdef", mem[63]);
        end
        checks++;
        if (we_cnt !== w0) begin
            errors++;
            $display("FAIL range_writes: got %0d want 0", we_cnt - w0);
        end
    endtask

    task automatic test_illegal_back_to_back();
        op_t ops [3];
        exp_t e;
        logic g_err;
        logic [31:0] g_rd;
        logic [3:0] g_lat;
        int w0;
        w0 = we_cnt;
        ops[0] = mk(1'b0, 3'b011, 32'h08, 32'h0, 1'b1, 32'h0, 4'd1);
        ops[1] = mk(1'b1, 3'b100, 32'h08, 32'h0000FFFF, 1'b1, 32'h0, 4'd1);
        ops[2] = mk(1'b0, F3_W, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 4'd2);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_t'{ops[i].err, ops[i].rdata, ops[i].lat});
            do_req(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, g_err, g_rd, g_lat);
            e = sb.pop_front();
            checks++;
            if ({g_err, g_rd, g_lat} !== {e.err, e.rdata, e.lat}) begin
                errors++;
                $display("FAIL illegal[%0d]: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                         i, g_err, g_rd, g_lat, e.err, e.rdata, e.lat);
            end
        end
        checks++;
        if (we_cnt !== w0 || mem[2] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL illegal_nowrite: got writes=%0d dm2=%h want 0/deadbeef",
                     we_cnt - w0, mem[2]);
        end
    endtask

    task automatic test_reset_mid();
        int rsp_seen;
        mem[3] <= TRAP ? 32'h77777777 : 32'h0;
        mem[4] <= 32'h55555555;
        rsp_seen = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = TRAP ? 32'h0C : 32'h0E;
        bus.req_wdata  = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (!TRAP) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid) rsp_seen++;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready_in_rst: got %b want 0", bus.req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        if (bus.rsp_valid) rsp_seen++;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready_after: got %b want 1", bus.req_ready);
        end
        checks++;
        if (rsp_seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_rsp: got %0d pulses want 0", rsp_seen);
        end
        checks++;
        if (mem[3] !== (TRAP ? 32'h77777777 : 32'hF00D0000)) begin
            errors++;
            $display("FAIL midrst_mem3: got %h want %h", mem[3],
                     TRAP ? 32'h77777777 : 32'hF00D0000);
        end
        checks++;
        if (mem[4] !== 32'h55555555) begin
            errors++;
            $display("FAIL midrst_mem4: got %h want 55555555", mem[4]);
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        we_cnt         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        @(negedge clk);
        test_reset();
        test_word();
        test_subword();
        test_span();
        test_range();
        test_illegal_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit in the MEM stage, between the EX/MEM pipeline register and the 64-word data memory. The memory offers only word-wide asynchronous read and synchronous write. This block turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses:
- read-modify-write for sub-word stores;
- two-word split for misaligned accesses;
- sign/zero extension of load data.

It stalls the pipeline through a valid/ready handshake.

Parameters:
MEM_WORDS, 64, data memory depth in words; a word index >= MEM_WORDS is out of range.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  EX/MEM presents an access
req_ready  out  1  LSU can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access fault, qualified by rsp_valid
dm_we  out  1  data memory write enable
dm_addr  out  32  data memory byte address, word-aligned (bits[1:0]=0)
dm_wd  out  32  data memory write data
dm_rd  in  32  data memory asynchronous read data

Behaviour:
- Reset, sampled at clk edge:
  - next state IDLE;
  - rsp_valid, rsp_err, dm_we = 0;
  - rsp_rdata = 0;
  - req_ready = 0 while rst is high.
- States:
  - IDLE: req_ready=1.
  - ACC1 / ACC2: req_ready=0.
  - RESP: req_ready=1; rsp_valid=1.
- Accept: req_valid & req_ready. Latch we, funct3, addr[1:0], word index, wdata.
- Size by funct3:
  - 000 / 100: byte.
  - 001 / 101: half.
  - 010: word.
  - Illegal: 011, 110, 111, and any store with funct3[2]=1.
- Span: the access crosses a word boundary when offset + size > 4 (half at offset 3; word at offset 1-3). The second word index is first + 1.
- Error: raised at accept if funct3 is illegal or any touched word index >= MEM_WORDS.
  - Next state is RESP with rsp_err=1 and rsp_rdata=0.
  - No dm_we is asserted for the request.
- Otherwise the next state is ACC1.
- ACC1:
  - dm_addr = {first index, 2'b00}.
  - Load: capture dm_rd into lo_q.
  - Store: dm_wd = dm_rd merged with shifted wdata under byte mask bits[3:0]; dm_we=1. Applies to full-word aligned stores too, where all four mask bits are set.
  - Next state: ACC2 if the access spans, else RESP.
- ACC2:
  - dm_addr = {first index + 1, 2'b00}.
  - Load: capture dm_rd into hi_q.
  - Store: merge under mask bits[7:4]; dm_we=1.
  - Next state: RESP.
- Little-endian layout:
  - 8-bit mask = size_mask << offset.
  - 64-bit data = wdata << (offset*8).
  - Load value = ({hi_q, lo_q} >> offset*8); LB/LH sign-extend, LBU/LHU zero-extend.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - A request accepted in RESP goes directly to ACC1 (or RESP again if it errors).
- Latency from accept at T:
  - non-spanning: rsp_valid at T+2;
  - spanning: rsp_valid at T+3;
  - error: rsp_valid at T+1.
- Outside ACC1/ACC2: dm_we=0 and dm_addr=0.
- Reset mid-operation:
  - Abort on the next edge; no response is issued.
  - A first-word write already committed in ACC1 is not rolled back.
- Simultaneous rst and req_valid: the request is dropped.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: any access with addr[1:0] not aligned to its size (half with addr[0]=1; word with addr[1:0]!=0) is an error at accept. Response at T+1 with rsp_err=1 and no memory write. ACC2 is never entered.
- Undefined: such accesses are split or handled in place as described above. rsp_err is raised only for illegal funct3 or out-of-range addresses.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - lsu_state_t enum {IDLE, ACC1, ACC2, RESP};
  - size-to-mask function.
- One sub-module lsu_align (combinational):
  - store shift/mask generation;
  - load byte extraction and extension;
  - span detection.
- mem_lsu holds the FSM, request latches, lo_q/hi_q and the memory port muxing.

Test Plan:
1. SW 0x08 data 0xDEADBEEF, then LW 0x08 -> dm[2]=0xDEADBEEF; load rsp_valid at T+2 with rsp_rdata 0xDEADBEEF, rsp_err=0.
2. dm[3]=0x11223344; SB 0x0D data 0x000000A5 -> dm[3]=0x1122A544; LB 0x0D -> 0xFFFFFFA5; LBU 0x0D -> 0x000000A5; LH 0x0E -> 0x00001122.
3. dm[3]=dm[4]=0; SW 0x0E data 0xCAFEF00D -> dm[3]=0xF00D0000, dm[4]=0x0000CAFE, rsp at T+3; LW 0x0E -> 0xCAFEF00D at T+3. With MISALIGN_TRAP_EN: both give rsp_err=1 at T+1, and dm is unchanged.
4. LW 0x100 -> rsp_err=1 at T+1, rsp_rdata=0, dm_we never high; SH 0xFF (spans words 63-64) -> rsp_err=1, dm[63] unchanged.
5. funct3=011 load and funct3=100 store -> rsp_err=1 at T+1, no write. A valid LW issued during the RESP cycle -> accepted, rsp at T+2.
6. rst asserted during ACC2 of SW 0x0E -> next cycle IDLE, no rsp_valid, dm[3] updated, dm[4] unchanged; req_ready=1 on the first cycle after rst deasserts.
